// File: rtl/iterative_right_shifter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iterative_right_shifter_pkg                                           |
// | Widths, stage sequencing constants and FSM encodings for the shifter. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package iterative_right_shifter_pkg;

    localparam int DATA_W      = 32;
    localparam int SHAMT_W     = 5;
    localparam int STAGE_CNT_W = 3;

    localparam logic [STAGE_CNT_W-1:0] LAST_STAGE = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : iterative_right_shifter_pkg
`default_nettype wire

// File: rtl/right_shift_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | right_shift_stage                                                     |
// | One barrel stage: select 0..4 means a distance of 16, 8, 4, 2, 1.     |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module right_shift_stage
    import iterative_right_shifter_pkg::*;
(
    input  logic [DATA_W-1:0]      value_i,
    input  logic [STAGE_CNT_W-1:0] dist_sel_i,
    input  logic                   en_i,
    input  logic                   fill_i,
    output logic [DATA_W-1:0]      value_o
);

    always_comb begin
        value_o = value_i;
        if (en_i) begin
            case (dist_sel_i)
                3'd0:    value_o = {{16{fill_i}}, value_i[DATA_W-1:16]};
                3'd1:    value_o = {{8{fill_i}},  value_i[DATA_W-1:8]};
                3'd2:    value_o = {{4{fill_i}},  value_i[DATA_W-1:4]};
                3'd3:    value_o = {{2{fill_i}},  value_i[DATA_W-1:2]};
                3'd4:    value_o = {fill_i,       value_i[DATA_W-1:1]};
                default: value_o = value_i;
            endcase
        end
    end

endmodule : right_shift_stage
`default_nettype wire

// File: rtl/iterative_right_shifter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iterative_right_shifter                                               |
// | Five-cycle logical/arithmetic right shifter, one stage per clock.     |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module iterative_right_shifter
    import iterative_right_shifter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic               ctrl_arith,
    input  logic               ctrl_start,
    output logic [DATA_W-1:0]  out,
    output logic               busy,
    output logic               data_resultRDY
);

    logic [1:0]             state_q, state_d;
    logic [STAGE_CNT_W-1:0] cnt_q,   cnt_d;
    logic [DATA_W-1:0]      val_q,   val_d;
    logic [SHAMT_W-1:0]     amt_q,   amt_d;
    logic                   fill_q,  fill_d;
    logic [DATA_W-1:0]      stage_out;

    // The amount register shifts left each stage, so its MSB is always the
    // bit belonging to the current distance (16 first, 1 last).
    right_shift_stage u_stage (
        .value_i    (val_q),
        .dist_sel_i (cnt_q),
        .en_i       (amt_q[SHAMT_W-1]),
        .fill_i     (fill_q),
        .value_o    (stage_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ctrl_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    val_d   = data_operand;
                    amt_d   = ctrl_shiftamt;
                    fill_d  = ctrl_arith & data_operand[DATA_W-1];
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                val_d = stage_out;
                amt_d = {amt_q[SHAMT_W-2:0], 1'b0};
                if (cnt_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            amt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
        end
    end

    // Intermediate stage values are visible on out during SHIFT.
    assign out            = val_q;
    assign busy           = (state_q == ST_SHIFT);
    assign data_resultRDY = (state_q == ST_DONE);

endmodule : iterative_right_shifter
`default_nettype wire

// File: tb/tb_iterative_right_shifter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_iterative_right_shifter                                            |
// | Directed vectors with hand-computed results, latency and busy checks. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_iterative_right_shifter;

    logic        clock;
    logic        reset;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_arith;
    logic        ctrl_start;
    logic [31:0] out;
    logic        busy;
    logic        data_resultRDY;

    int n_cmp = 0;
    int n_err = 0;

    iterative_right_shifter dut (
        .clock          (clock),
        .reset          (reset),
        .data_operand   (data_operand),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .ctrl_arith     (ctrl_arith),
        .ctrl_start     (ctrl_start),
        .out            (out),
        .busy           (busy),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the accepting edge.
    task automatic start_op(input logic [31:0] op, input logic [4:0] amt, input logic ar);
        data_operand  = op;
        ctrl_shiftamt = amt;
        ctrl_arith    = ar;
        ctrl_start    = 1'b1;
        @(negedge clock);
        ctrl_start    = 1'b0;
        data_operand  = 32'hDEAD_BEEF;
        ctrl_shiftamt = 5'd17;
        ctrl_arith    = ~ar;
    endtask

    // glitch_at >= 0 drives a spurious start (op 1, amt 1) in that SHIFT cycle.
    task automatic wait_result(input string tag, input logic [31:0] exp, input int glitch_at);
        int cycles = 0;
        int busy_n = 0;
        while (!data_resultRDY && cycles < 20) begin
            ctrl_start = (cycles == glitch_at);
            if (cycles == glitch_at) begin
                data_operand  = 32'h0000_0001;
                ctrl_shiftamt = 5'd1;
                ctrl_arith    = 1'b0;
            end
            if (busy) busy_n++;
            @(negedge clock);
            cycles++;
        end
        ctrl_start = 1'b0;
        check({tag, " latency"}, 32'(cycles), 32'd5);
        check({tag, " busy cycles"}, 32'(busy_n), 32'd5);
        check({tag, " out"}, out, exp);
        check({tag, " busy in DONE"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit saw_rdy;
        reset         = 1'b1;
        data_operand  = '0;
        ctrl_shiftamt = '0;
        ctrl_arith    = 1'b0;
        ctrl_start    = 1'b1;
        repeat (3) @(negedge clock);
        check("reset out", out, 32'h0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        ctrl_start = 1'b0;
        reset      = 1'b0;
        @(negedge clock);

        start_op(32'h8000_0000, 5'd31, 1'b1);
        wait_result("asr31", 32'hFFFF_FFFF, -1);
        @(negedge clock);
        check("asr31 rdy one cycle", {31'd0, data_resultRDY}, 32'd0);
        check("asr31 out held", out, 32'hFFFF_FFFF);

        start_op(32'h8000_0000, 5'd31, 1'b0);
        wait_result("lsr31", 32'h0000_0001, -1);
        @(negedge clock);
        start_op(32'hF0F0_F0F0, 5'd4, 1'b0);
        wait_result("lsr4", 32'h0F0F_0F0F, -1);
        @(negedge clock);
        start_op(32'h1234_5678, 5'd0, 1'b1);
        wait_result("amt0", 32'h1234_5678, -1);
        @(negedge clock);
        start_op(32'h7FFF_FFFF, 5'd4, 1'b1);
        wait_result("asr pos", 32'h07FF_FFFF, -1);
        @(negedge clock);
        start_op(32'hFFFF_FFFF, 5'd16, 1'b0);
        wait_result("lsr16", 32'h0000_FFFF, -1);
        @(negedge clock);
        start_op(32'h8000_0000, 5'd21, 1'b1);
        wait_result("asr21", 32'hFFFF_FC00, -1);
        @(negedge clock);

        start_op(32'hFFFF_0000, 5'd8, 1'b1);
        wait_result("ignore start", 32'hFFFF_FF00, 1);
        @(negedge clock);

        // Abort: reset lands on the third SHIFT edge.
        start_op(32'h1234_5678, 5'd3, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort out", out, 32'h0);
        check("abort busy", {31'd0, busy}, 32'd0);
        saw_rdy = data_resultRDY;
        repeat (8) begin
            @(negedge clock);
            saw_rdy = saw_rdy | data_resultRDY;
        end
        check("abort no rdy", {31'd0, saw_rdy}, 32'd0);
        start_op(32'h0000_0100, 5'd8, 1'b0);
        wait_result("after abort", 32'h0000_0001, -1);

        // Back-to-back: new start issued in the DONE cycle.
        start_op(32'hA000_0000, 5'd1, 1'b1);
        wait_result("b2b", 32'hD000_0000, -1);
        start_op(32'h8000_0000, 5'd2, 1'b0);
        wait_result("b2b second", 32'h2000_0000, -1);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_iterative_right_shifter
`default_nettype wire
